packet_header_parser: RTL and testbench

Stream-side parser for the packet buffer's framed format, in which each packet is one header beat followed by its payload. The block strips the header, splits the packet_length and interface_id fields out of it, and re-emits the payload as a framed stream with per-byte keep, last and a channel index. Packets with an illegal length or an out-of-range interface are consumed and discarded, and an error pulse is raised. It sits between the packet buffer read side and the per-interface capture/egress logic.

---
 rtl/packet_header_parser.sv | 168 ++++++++++++++++
 tb/tb_packet_header_parser.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_header_parser.sv
// rtl/packet_header_parser.sv - strips the header beat and re-emits the payload with keep/last/channel
module packet_header_parser #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int MAX_LENGTH   = 1500,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic [DATA_WIDTH/8-1:0]   m_keep,
    output logic                      m_last,
    output logic [CH_W-1:0]           m_channel,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      err_length,
    output logic                      err_channel,
    output logic [15:0]               drop_count
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LENGTH);
    localparam logic [16:0] NUM_CH_W  = 17'(NUM_CHANNELS);
    localparam logic [15:0] BYTES_W   = 16'(BYTES);

    typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP} state_t;

    state_t                state_q, state_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [CH_W-1:0]       chan_q, chan_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [BYTES-1:0]      m_keep_q, m_keep_d;
    logic                  m_last_q, m_last_d;
    logic [CH_W-1:0]       m_channel_q, m_channel_d;
    logic                  m_valid_q, m_valid_d;
    logic                  err_length_q, err_length_d;
    logic                  err_channel_q, err_channel_d;
    logic [15:0]           drop_count_q, drop_count_d;

    logic                  accept;
    logic                  last_beat;
    logic                  drop_inc;
    logic [BYTES-1:0]      beat_keep;
    logic [15:0]           hdr_len;
    logic [15:0]           hdr_id;

    // Header beats are never stalled; payload beats wait for the single output register
    assign s_ready = (state_q == S_PAYLOAD) ? (!m_valid_q || m_ready) : 1'b1;
    assign accept  = s_valid && s_ready;
    assign hdr_len = s_data[15:0];
    assign hdr_id  = s_data[31:16];

    assign m_data      = m_data_q;
    assign m_keep      = m_keep_q;
    assign m_last      = m_last_q;
    assign m_channel   = m_channel_q;
    assign m_valid     = m_valid_q;
    assign err_length  = err_length_q;
    assign err_channel = err_channel_q;
    assign drop_count  = drop_count_q;

    // Next-state, output register load and drop accounting
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        chan_d        = chan_q;
        m_data_d      = m_data_q;
        m_keep_d      = m_keep_q;
        m_last_d      = m_last_q;
        m_channel_d   = m_channel_q;
        m_valid_d     = m_valid_q;
        err_length_d  = 1'b0;
        err_channel_d = 1'b0;
        drop_inc      = 1'b0;

        last_beat = (remaining_q <= BYTES_W);
        for (int i = 0; i < BYTES; i++) begin
            beat_keep[i] = last_beat ? (16'(i) < remaining_q) : 1'b1;
        end

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            S_HDR: begin
                if (accept) begin
                    remaining_d = hdr_len;
                    if (hdr_len == 16'd0) begin
                        err_length_d = 1'b1;
                        drop_inc     = 1'b1;
                    end else if ({1'b0, hdr_len} > MAX_LEN_W) begin
                        err_length_d = 1'b1;
                        state_d      = S_DROP;
                    end else if ({1'b0, hdr_id} >= NUM_CH_W) begin
                        err_channel_d = 1'b1;
                        state_d       = S_DROP;
                    end else begin
                        chan_d  = hdr_id[CH_W-1:0];
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    m_valid_d   = 1'b1;
                    m_data_d    = s_data;
                    m_keep_d    = beat_keep;
                    m_last_d    = last_beat;
                    m_channel_d = chan_q;
                    if (last_beat) begin
                        remaining_d = 16'd0;
                        state_d     = S_HDR;
                    end else begin
                        remaining_d = remaining_q - BYTES_W;
                    end
                end
            end
            S_DROP: begin
                if (accept) begin
                    if (last_beat) begin
                        remaining_d = 16'd0;
                        drop_inc    = 1'b1;
                        state_d     = S_HDR;
                    end else begin
                        remaining_d = remaining_q - BYTES_W;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase

        drop_count_d = (drop_inc && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_HDR;
            remaining_q   <= 16'd0;
            chan_q        <= '0;
            m_data_q      <= '0;
            m_keep_q      <= '0;
            m_last_q      <= 1'b0;
            m_channel_q   <= '0;
            m_valid_q     <= 1'b0;
            err_length_q  <= 1'b0;
            err_channel_q <= 1'b0;
            drop_count_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            chan_q        <= chan_d;
            m_data_q      <= m_data_d;
            m_keep_q      <= m_keep_d;
            m_last_q      <= m_last_d;
            m_channel_q   <= m_channel_d;
            m_valid_q     <= m_valid_d;
            err_length_q  <= err_length_d;
            err_channel_q <= err_channel_d;
            drop_count_q  <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_packet_header_parser.sv
// tb/tb_packet_header_parser.sv - directed-vector bench for packet_header_parser
module tb_packet_header_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic [1:0]  m_channel;
    logic        m_valid;
    logic        m_ready;
    logic        err_length;
    logic        err_channel;
    logic [15:0] drop_count;

    int n_vec = 0;
    int n_bad = 0;
    bit toggle_en = 1'b0;

    int err_len_cnt = 0;
    int err_ch_cnt  = 0;
    int mvalid_cnt  = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    logic        q_last[$];
    logic [1:0]  q_ch[$];

    packet_header_parser #(
        .DATA_WIDTH(32), .NUM_CHANNELS(4), .MAX_LENGTH(1500)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_channel(m_channel),
        .m_valid(m_valid), .m_ready(m_ready),
        .err_length(err_length), .err_channel(err_channel), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor on the falling edge: records handshakes, counts pulses, checks stall behaviour
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        prev_last;
    logic [1:0]  prev_ch;
    always @(negedge clk) begin
        if (!rst) begin
            if (err_length)  err_len_cnt++;
            if (err_channel) err_ch_cnt++;
            if (m_valid)     mvalid_cnt++;
            if (prev_stall && m_valid) begin
                check_eq("stall_data", m_data, prev_data);
                check_eq("stall_keep", 32'(m_keep), 32'(prev_keep));
                check_eq("stall_last", 32'(m_last), 32'(prev_last));
                check_eq("stall_chan", 32'(m_channel), 32'(prev_ch));
            end
            if (m_valid && !m_ready && !m_last) begin
                check_eq("stall_s_ready", 32'(s_ready), 32'd0);
            end
            if (m_valid && m_ready) begin
                q_data.push_back(m_data);
                q_keep.push_back(m_keep);
                q_last.push_back(m_last);
                q_ch.push_back(m_channel);
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_keep  = m_keep;
        prev_last  = m_last;
        prev_ch    = m_channel;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) m_ready = ~m_ready;
    endtask

    task automatic send(input logic [31:0] d);
        bit ok;
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            @(negedge clk);
            ok = s_ready;
            tick();
            n++;
        end while (!ok && n < 100);
        if (!ok) check_eq("s_ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_q();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        q_ch.delete();
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [31:0] d,
                            input logic [3:0] k, input logic l, input logic [1:0] c);
        if (i < q_data.size()) begin
            check_eq({tag, "_data"}, q_data[i], d);
            check_eq({tag, "_keep"}, 32'(q_keep[i]), 32'(k));
            check_eq({tag, "_last"}, 32'(q_last[i]), 32'(l));
            check_eq({tag, "_chan"}, 32'(q_ch[i]), 32'(c));
        end else begin
            check_eq({tag, "_missing"}, 32'(q_data.size()), 32'(i + 1));
        end
    endtask

    int mv_before;

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        flush(3);
        rst = 1'b0;

        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_m_last", 32'(m_last), 32'd0);
        check_eq("rst_m_keep", 32'(m_keep), 32'd0);
        check_eq("rst_m_data", m_data, 32'd0);
        check_eq("rst_m_chan", 32'(m_channel), 32'd0);
        check_eq("rst_err_len", 32'(err_length), 32'd0);
        check_eq("rst_err_ch", 32'(err_channel), 32'd0);
        check_eq("rst_drops", 32'(drop_count), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd1);

        // 5-byte packet on interface 2
        clear_q();
        send(32'h0002_0005);
        send(32'h1122_3344);
        send(32'h5566_7788);
        flush(3);
        check_eq("p1_beats", 32'(q_data.size()), 32'd2);
        chk_beat("p1_b0", 0, 32'h1122_3344, 4'b1111, 1'b0, 2'd2);
        chk_beat("p1_b1", 1, 32'h5566_7788, 4'b0001, 1'b1, 2'd2);

        // length 1501 > MAX_LENGTH: 376 beats dropped
        clear_q();
        mv_before = mvalid_cnt;
        send(32'h0001_05DD);
        for (int i = 0; i < 376; i++) send(32'hA500_0000 + 32'(i));
        check_eq("p2_mvalid", 32'(mvalid_cnt - mv_before), 32'd0);
        check_eq("p2_err_len", 32'(err_len_cnt), 32'd1);
        check_eq("p2_err_ch", 32'(err_ch_cnt), 32'd0);
        check_eq("p2_drops", 32'(drop_count), 32'd1);
        send(32'h0001_0004);
        send(32'h0BAD_BEEF);
        flush(3);
        check_eq("p2_next_beats", 32'(q_data.size()), 32'd1);
        chk_beat("p2_next", 0, 32'h0BAD_BEEF, 4'b1111, 1'b1, 2'd1);

        // interface 9 out of range: 2 beats dropped
        clear_q();
        send(32'h0009_0008);
        send(32'h1111_1111);
        send(32'h2222_2222);
        flush(2);
        check_eq("p3_err_ch", 32'(err_ch_cnt), 32'd1);
        check_eq("p3_err_len", 32'(err_len_cnt), 32'd1);
        check_eq("p3_drops", 32'(drop_count), 32'd2);
        check_eq("p3_beats", 32'(q_data.size()), 32'd0);

        // zero length: next beat is a header
        clear_q();
        send(32'h0000_0000);
        send(32'h0003_0003);
        send(32'hAABB_CCDD);
        flush(3);
        check_eq("p4_err_len", 32'(err_len_cnt), 32'd2);
        check_eq("p4_err_ch", 32'(err_ch_cnt), 32'd1);
        check_eq("p4_drops", 32'(drop_count), 32'd3);
        check_eq("p4_beats", 32'(q_data.size()), 32'd1);
        chk_beat("p4_b0", 0, 32'hAABB_CCDD, 4'b0111, 1'b1, 2'd3);

        // 12-byte packet with m_ready toggling every cycle
        clear_q();
        toggle_en = 1'b1;
        send(32'h0001_000C);
        send(32'hC000_0001);
        send(32'hC000_0002);
        send(32'hC000_0003);
        flush(8);
        toggle_en = 1'b0;
        m_ready   = 1'b1;
        flush(2);
        check_eq("p5_beats", 32'(q_data.size()), 32'd3);
        chk_beat("p5_b0", 0, 32'hC000_0001, 4'b1111, 1'b0, 2'd1);
        chk_beat("p5_b1", 1, 32'hC000_0002, 4'b1111, 1'b0, 2'd1);
        chk_beat("p5_b2", 2, 32'hC000_0003, 4'b1111, 1'b1, 2'd1);

        // reset after first beat of a 3-beat packet
        send(32'h0002_000C);
        send(32'hDEAD_0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("p6_m_valid", 32'(m_valid), 32'd0);
        check_eq("p6_m_data", m_data, 32'd0);
        check_eq("p6_m_keep", 32'(m_keep), 32'd0);
        check_eq("p6_m_last", 32'(m_last), 32'd0);
        check_eq("p6_m_chan", 32'(m_channel), 32'd0);
        check_eq("p6_drops", 32'(drop_count), 32'd0);
        clear_q();
        send(32'h0003_0004);
        send(32'hCAFE_F00D);
        flush(3);
        check_eq("p6_beats", 32'(q_data.size()), 32'd1);
        chk_beat("p6_b0", 0, 32'hCAFE_F00D, 4'b1111, 1'b1, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
